// File: rtl/forward_ctrl_unit.sv
// Hazard/forwarding controller for the decode->execute boundary.
// It tracks EX/MEM/WB destinations, drives the operand forward-select codes,
// and sequences load-use stalls, multi-cycle EX occupancy and branch flushes.

// Guards the protocol: a taken branch cannot resolve while a multi-cycle op holds EX.
module forward_ctrl_unit_chk (
    input  logic clk,
    input  logic reset_n,
    input  logic mc_wait,
    input  logic branch_taken
);
    a_no_branch_in_mc_wait : assert property (@(posedge clk) disable iff (!reset_n)
        !(mc_wait && branch_taken));
endmodule

module forward_ctrl_unit #(
    parameter int REG_W     = 6,
    parameter int MC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_is_multi,
    input  logic             branch_taken,
    output logic [2:0]       forward_data,
    output logic [2:0]       forward_data2,
    output logic             stall_if_id,
    output logic             hold_id_ex,
    output logic             busy
);
    // Tracker entry layout: {valid, wr_en, is_load, rd}
    localparam int ENT_W  = REG_W + 3;
    localparam int B_VAL  = REG_W + 2;
    localparam int B_WR   = REG_W + 1;
    localparam int B_LOAD = REG_W;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MC_WAIT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ENT_W-1:0] ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [ENT_W-1:0] id_ent_s;
    logic             load_use_s;
    logic             bubble_s;
    logic [2:0]       sel1_s, sel2_s;

    // A used, non-zero source hits a valid, writing entry with the same rd.
    function automatic logic ent_hit(input logic [ENT_W-1:0] ent,
                                     input logic [REG_W-1:0] src,
                                     input logic             used);
        ent_hit = used && (src != {REG_W{1'b0}}) && ent[B_VAL] && ent[B_WR]
                  && (ent[REG_W-1:0] == src);
    endfunction

    // Operand source with EX > MEM > WB priority; a load in EX cannot forward yet.
    function automatic logic [2:0] fwd_sel(input logic [ENT_W-1:0] ex_e,
                                           input logic [ENT_W-1:0] mem_e,
                                           input logic [ENT_W-1:0] wb_e,
                                           input logic [REG_W-1:0] src,
                                           input logic             used);
        if (ent_hit(ex_e, src, used) && !ex_e[B_LOAD]) begin
            fwd_sel = 3'b001;
        end else if (ent_hit(mem_e, src, used)) begin
            fwd_sel = mem_e[B_LOAD] ? 3'b101 : 3'b011;
        end else if (ent_hit(wb_e, src, used)) begin
            fwd_sel = 3'b110;
        end else begin
            fwd_sel = 3'b000;
        end
    endfunction

    // Hazard detection and next-state / next-tracker computation.
    always_comb begin
        id_ent_s   = {id_valid, id_wr_en, id_is_load, id_rd};
        load_use_s = id_valid && (state_q == ST_RUN) &&
                     ((ent_hit(ex_q, id_rs1, id_rs1_used) && ex_q[B_LOAD]) ||
                      (ent_hit(ex_q, id_rs2, id_rs2_used) && ex_q[B_LOAD]));
        bubble_s   = branch_taken || load_use_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_d       = id_ent_s;
        mem_d      = ex_q;
        wb_d       = mem_q;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    ex_d = {ENT_W{1'b0}};
                end else if (load_use_s) begin
                    ex_d    = {ENT_W{1'b0}};
                    state_d = ST_LOAD_STALL;
                end else if (id_valid && id_is_multi) begin
                    state_d = ST_MC_WAIT;
                    cnt_d   = 4'(MC_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD_STALL: begin
                if (branch_taken) begin
                    ex_d    = {ENT_W{1'b0}};
                    state_d = ST_RUN;
                end else if (id_valid && id_is_multi) begin
                    state_d = ST_MC_WAIT;
                    cnt_d   = 4'(MC_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                ex_d  = ex_q;
                mem_d = {ENT_W{1'b0}};
                wb_d  = mem_q;
                if (branch_taken) begin
                    ex_d    = {ENT_W{1'b0}};
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
                ex_d    = {ENT_W{1'b0}};
            end
        endcase
    end

    // Forward codes and stall/hold outputs; quiet while reset is asserted.
    always_comb begin
        sel1_s = bubble_s ? 3'b111 : fwd_sel(ex_q, mem_q, wb_q, id_rs1, id_rs1_used);
        sel2_s = bubble_s ? 3'b111 : fwd_sel(ex_q, mem_q, wb_q, id_rs2, id_rs2_used);
        if (reset_n) begin
            forward_data  = sel1_s;
            forward_data2 = sel2_s;
            stall_if_id   = (state_q == ST_MC_WAIT) || (load_use_s && !branch_taken);
            hold_id_ex    = (state_q == ST_MC_WAIT);
            busy          = (state_q != ST_RUN);
        end else begin
            forward_data  = 3'b000;
            forward_data2 = 3'b000;
            stall_if_id   = 1'b0;
            hold_id_ex    = 1'b0;
            busy          = 1'b0;
        end
    end

    // State, counter and pipeline tracker registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            ex_q    <= {ENT_W{1'b0}};
            mem_q   <= {ENT_W{1'b0}};
            wb_q    <= {ENT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    forward_ctrl_unit_chk u_chk (
        .clk          (clk),
        .reset_n      (reset_n),
        .mc_wait      (state_q == ST_MC_WAIT),
        .branch_taken (branch_taken)
    );
endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Directed-vector bench for forward_ctrl_unit (REG_W=6, MC_CYCLES=4).
module tb_forward_ctrl_unit;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load, id_is_multi;
    logic       branch_taken;
    logic [5:0] id_rs1, id_rs2, id_rd;
    logic [2:0] forward_data, forward_data2;
    logic       stall_if_id, hold_id_ex, busy;
    int         n_vec = 0;
    int         n_err = 0;

    forward_ctrl_unit #(.REG_W(6), .MC_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
        .id_is_load(id_is_load), .id_is_multi(id_is_multi),
        .branch_taken(branch_taken), .forward_data(forward_data),
        .forward_data2(forward_data2), .stall_if_id(stall_if_id),
        .hold_id_ex(hold_id_ex), .busy(busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one ID slot just after the falling edge, then settle before sampling.
    task automatic drive(input logic v, input logic [5:0] rs1, input logic u1,
                         input logic [5:0] rs2, input logic u2, input logic [5:0] rd,
                         input logic wr, input logic ld, input logic mc, input logic br);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_wr_en = wr; id_is_load = ld; id_is_multi = mc; branch_taken = br;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle(2);
        check_val("rst_fd", {5'd0, forward_data}, 8'h00);
        check_val("rst_fd2", {5'd0, forward_data2}, 8'h00);
        check_val("rst_stall", {7'd0, stall_if_id}, 8'h00);
        check_val("rst_busy", {7'd0, busy}, 8'h00);
        reset_n = 1'b1;
        idle(1);

        // ALU chain: add x5 ; sub uses x5 ; then MEM ; then WB
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("alu_first", {5'd0, forward_data}, 8'h00);
        drive(1'b1, 6'd5, 1'b1, 6'd6, 1'b1, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("alu_ex_fd", {5'd0, forward_data}, 8'h01);
        check_val("alu_ex_fd2", {5'd0, forward_data2}, 8'h00);
        drive(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("alu_mem_fd", {5'd0, forward_data}, 8'h03);
        drive(1'b1, 6'd5, 1'b1, 6'd8, 1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("alu_wb_fd", {5'd0, forward_data}, 8'h06);
        check_val("alu_indep_fd2", {5'd0, forward_data2}, 8'h03);
        idle(3);

        // EX wins over MEM for the same rd
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("prio_ex", {5'd0, forward_data}, 8'h01);
        idle(3);

        // Load-use: lw x7 ; add rs2=x7
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("lw_issue_stall", {7'd0, stall_if_id}, 8'h00);
        drive(1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("lu_fd2", {5'd0, forward_data2}, 8'h07);
        check_val("lu_fd", {5'd0, forward_data}, 8'h07);
        check_val("lu_stall", {7'd0, stall_if_id}, 8'h01);
        drive(1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("lu2_fd2", {5'd0, forward_data2}, 8'h05);
        check_val("lu2_stall", {7'd0, stall_if_id}, 8'h00);
        idle(1);
        check_val("lu_busy_clr", {7'd0, busy}, 8'h00);
        idle(3);

        // x0: load writer rd=0, reader rs1=0
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("x0_fd", {5'd0, forward_data}, 8'h00);
        check_val("x0_stall", {7'd0, stall_if_id}, 8'h00);
        idle(3);

        // Multi-cycle op writing x12, dependent instr held in ID
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("mc_issue_busy", {7'd0, busy}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'd12, 1'b1, 6'd0, 1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("mc_stall%0d", i), {7'd0, stall_if_id}, 8'h01);
            check_val($sformatf("mc_hold%0d", i), {7'd0, hold_id_ex}, 8'h01);
            check_val($sformatf("mc_busy%0d", i), {7'd0, busy}, 8'h01);
        end
        drive(1'b1, 6'd12, 1'b1, 6'd0, 1'b0, 6'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("mc_end_stall", {7'd0, stall_if_id}, 8'h00);
        check_val("mc_end_hold", {7'd0, hold_id_ex}, 8'h00);
        check_val("mc_end_busy", {7'd0, busy}, 8'h00);
        check_val("mc_dep_fd", {5'd0, forward_data}, 8'h01);
        idle(3);

        // Flush coincident with a load-use detect
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 6'd7, 1'b1, 6'd0, 1'b0, 6'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("fl_fd", {5'd0, forward_data}, 8'h07);
        check_val("fl_fd2", {5'd0, forward_data2}, 8'h07);
        check_val("fl_stall", {7'd0, stall_if_id}, 8'h00);
        drive(1'b1, 6'd11, 1'b1, 6'd7, 1'b1, 6'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("fl_next_busy", {7'd0, busy}, 8'h00);
        check_val("fl_ex_inval", {5'd0, forward_data}, 8'h00);
        check_val("fl_mem_load", {5'd0, forward_data2}, 8'h05);
        idle(3);

        // Reset in MC_WAIT with counter at 2
        drive(1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        check_val("rmc_in_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        id_valid = 1'b1; id_rs1 = 6'd12; id_rs1_used = 1'b1; id_rd = 6'd15; id_wr_en = 1'b1;
        #2;
        check_val("rmc_busy", {7'd0, busy}, 8'h00);
        check_val("rmc_fd", {5'd0, forward_data}, 8'h00);
        check_val("rmc_fd2", {5'd0, forward_data2}, 8'h00);
        check_val("rmc_stall", {7'd0, stall_if_id}, 8'h00);
        check_val("rmc_hold", {7'd0, hold_id_ex}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
